// File: rtl/fifo2linebuf_pkg.sv
// -----------------------------------------------------------------------------
// linebuf_pkg
// Shared definitions for the FIFO-to-line-buffer writer:
//   - FSM state encoding (IDLE, RD, CHK, STALL)
//   - bit positions of the 29-bit video FIFO word
//       [28]    spare
//       [27]    chunk bit
//       [26:16] line number y
//       [15:0]  YUV422 pixel
//   - a packed {y, pix} view of the word plus an unpack helper
// -----------------------------------------------------------------------------
package linebuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    CHK   = 2'd2,
    STALL = 2'd3
  } lb_state_e;

  localparam int WORD_W    = 29;
  localparam int CHUNK_BIT = 27;
  localparam int Y_MSB     = 26;
  localparam int Y_LSB     = 16;
  localparam int PIX_MSB   = 15;
  localparam int Y_W       = Y_MSB - Y_LSB + 1;
  localparam int PIX_W     = PIX_MSB + 1;

  typedef struct packed {
    logic [Y_W-1:0]   y;
    logic [PIX_W-1:0] pix;
  } lb_pix_t;

  // Takes only the y/pixel part of the word; the chunk bit is not used here.
  function automatic lb_pix_t lb_unpack(input logic [Y_MSB:0] w);
    lb_pix_t p;
    p.y   = w[Y_MSB:Y_LSB];
    p.pix = w[PIX_MSB:0];
    return p;
  endfunction

endpackage

// File: rtl/fifo2linebuf_if.sv
// -----------------------------------------------------------------------------
// fifo2linebuf_if
// Bundles the video-FIFO read side, the line-buffer write side and the
// line-closed notification of fifo2linebuf.
//   fifo_dout  [28:0]     FIFO word (valid the cycle after fifo_rd_en)
//   fifo_empty            FIFO empty flag
//   fifo_rd_en            FIFO read strobe
//   bank_free  [1:0]      per-bank "writable" from the display side
//   buf_we                line-buffer write enable
//   buf_addr   [ADDR_W:0] {bank, pixel index}
//   buf_wdata  [15:0]     pixel written
//   line_done             one-cycle pulse when a line is closed
//   line_num   [10:0]     y of the closed line
//   line_bank             bank of the closed line
// master: the line-buffer writer.  slave: FIFO / RAM / display environment.
// -----------------------------------------------------------------------------
interface fifo2linebuf_if
  import linebuf_pkg::*;
#(
  parameter int ADDR_W = 11
);
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [1:0]        bank_free;
  logic              buf_we;
  logic [ADDR_W:0]   buf_addr;
  logic [PIX_W-1:0]  buf_wdata;
  logic              line_done;
  logic [Y_W-1:0]    line_num;
  logic              line_bank;

  modport master (
    input  fifo_dout, fifo_empty, bank_free,
    output fifo_rd_en, buf_we, buf_addr, buf_wdata, line_done, line_num, line_bank
  );

  modport slave (
    output fifo_dout, fifo_empty, bank_free,
    input  fifo_rd_en, buf_we, buf_addr, buf_wdata, line_done, line_num, line_bank
  );
endinterface

// File: rtl/fifo2linebuf.sv
// -----------------------------------------------------------------------------
// fifo2linebuf
// Drains a video FIFO of {chunk, y, pixel} words into an external ping-pong
// line buffer (two banks of 2**ADDR_W pixels). One read per two cycles: RD
// strobes the FIFO, CHK consumes the word the next cycle and either writes
// it, drops it, or closes a short line and parks the word in STALL until the
// next bank is free.
//
// Parameters
//   H_ACTIVE  pixels per line (default 1280)
//   ADDR_W    in-bank address width, 2**ADDR_W >= H_ACTIVE (default 11)
// Ports
//   clk125    clock, rising edge
//   sys_rst   asynchronous active-high reset
//   bus       fifo2linebuf_if.master (FIFO read, buffer write, line_done)
//   err_flags sticky: [0] pixel dropped after its line closed, [1] short line
//   drop_cnt / short_cnt (only with LINEBUF_STATS_EN): saturating 16-bit
//             event counters for err_flags[0] / err_flags[1] events
// Build option
//   LINEBUF_STATS_EN  adds drop_cnt and short_cnt
// -----------------------------------------------------------------------------
module fifo2linebuf
  import linebuf_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int ADDR_W   = 11
) (
  input  logic              clk125,
  input  logic              sys_rst,
  fifo2linebuf_if.master    bus,
  output logic [1:0]        err_flags
`ifdef LINEBUF_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       short_cnt
`endif
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(H_ACTIVE - 1);
  localparam logic [ADDR_W:0] ONE_IDX  = (ADDR_W+1)'(1);

  lb_state_e         state_q, state_d;
  logic              cur_bank_q, cur_bank_d;
  logic [ADDR_W:0]   pix_cnt_q, pix_cnt_d;
  logic [Y_W-1:0]    cur_y_q, cur_y_d;
  logic [Y_W-1:0]    last_y_q, last_y_d;
  logic              closed_q, closed_d;
  lb_pix_t           stage_q, stage_d;

  logic              buf_we_q, buf_we_d;
  logic [ADDR_W:0]   buf_addr_q, buf_addr_d;
  logic [PIX_W-1:0]  buf_wdata_q, buf_wdata_d;
  logic              line_done_q, line_done_d;
  logic [Y_W-1:0]    line_num_q, line_num_d;
  logic              line_bank_q, line_bank_d;
  logic [1:0]        err_q, err_d;

  logic              rd_ok;
  logic              drop_evt;
  logic              short_evt;
  lb_pix_t           word;

  assign word = lb_unpack(bus.fifo_dout[Y_MSB:0]);

  // Chunk bit and spare bit are carried by the FIFO but not needed here.
  logic unused_hi;
  assign unused_hi = ^bus.fifo_dout[WORD_W-1:CHUNK_BIT];

  // Another read may start only while data is present and the bank being
  // filled is still writable; a bank going busy mid-line simply parks us in
  // IDLE after the read already in flight has been consumed.
  assign rd_ok = !bus.fifo_empty && bus.bank_free[cur_bank_q];

  always_comb begin
    state_d     = state_q;
    cur_bank_d  = cur_bank_q;
    pix_cnt_d   = pix_cnt_q;
    cur_y_d     = cur_y_q;
    last_y_d    = last_y_q;
    closed_d    = closed_q;
    stage_d     = stage_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    line_done_d = 1'b0;
    line_num_d  = line_num_q;
    line_bank_d = line_bank_q;
    err_d       = err_q;
    drop_evt    = 1'b0;
    short_evt   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_ok) state_d = RD;
      end

      RD: begin
        state_d = CHK;
      end

      CHK: begin
        state_d = rd_ok ? RD : IDLE;
        if (closed_q && (word.y == last_y_q)) begin
          // Surplus pixel of a line that already received H_ACTIVE pixels.
          drop_evt = 1'b1;
          err_d[0] = 1'b1;
        end else if ((pix_cnt_q == '0) || (word.y == cur_y_q)) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = {cur_bank_q, pix_cnt_q[ADDR_W-1:0]};
          buf_wdata_d = word.pix;
          cur_y_d     = word.y;
          closed_d    = 1'b0;
          if (pix_cnt_q == LAST_IDX) begin
            line_done_d = 1'b1;
            line_num_d  = word.y;
            line_bank_d = cur_bank_q;
            cur_bank_d  = ~cur_bank_q;
            pix_cnt_d   = '0;
            closed_d    = 1'b1;
            last_y_d    = word.y;
            state_d     = IDLE;
          end else begin
            pix_cnt_d = pix_cnt_q + ONE_IDX;
          end
        end else begin
          // New y before the line was full: close it short and keep the
          // word, it becomes pixel 0 of the next bank once that is free.
          line_done_d = 1'b1;
          line_num_d  = cur_y_q;
          line_bank_d = cur_bank_q;
          err_d[1]    = 1'b1;
          short_evt   = 1'b1;
          cur_bank_d  = ~cur_bank_q;
          pix_cnt_d   = '0;
          stage_d     = word;
          state_d     = STALL;
        end
      end

      STALL: begin
        if (bus.bank_free[cur_bank_q]) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = {cur_bank_q, {ADDR_W{1'b0}}};
          buf_wdata_d = stage_q.pix;
          cur_y_d     = stage_q.y;
          pix_cnt_d   = ONE_IDX;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk125 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cur_bank_q  <= 1'b0;
      pix_cnt_q   <= '0;
      cur_y_q     <= '0;
      last_y_q    <= '0;
      closed_q    <= 1'b0;
      stage_q     <= '0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      line_done_q <= 1'b0;
      line_num_q  <= '0;
      line_bank_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_bank_q  <= cur_bank_d;
      pix_cnt_q   <= pix_cnt_d;
      cur_y_q     <= cur_y_d;
      last_y_q    <= last_y_d;
      closed_q    <= closed_d;
      stage_q     <= stage_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      line_done_q <= line_done_d;
      line_num_q  <= line_num_d;
      line_bank_q <= line_bank_d;
      err_q       <= err_d;
    end
  end

  // Read strobe is decoded from the state so reset removes it at once.
  assign bus.fifo_rd_en = (state_q == RD);
  assign bus.buf_we     = buf_we_q;
  assign bus.buf_addr   = buf_addr_q;
  assign bus.buf_wdata  = buf_wdata_q;
  assign bus.line_done  = line_done_q;
  assign bus.line_num   = line_num_q;
  assign bus.line_bank  = line_bank_q;
  assign err_flags      = err_q;

`ifdef LINEBUF_STATS_EN
  logic [15:0] drop_cnt_q, short_cnt_q;

  always_ff @(posedge clk125 or posedge sys_rst) begin
    if (sys_rst) begin
      drop_cnt_q  <= '0;
      short_cnt_q <= '0;
    end else begin
      if (drop_evt && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
      if (short_evt && (short_cnt_q != 16'hFFFF))
        short_cnt_q <= short_cnt_q + 16'd1;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign short_cnt = short_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = drop_evt ^ short_evt;
`endif

endmodule

// File: tb/tb_fifo2linebuf.sv
// -----------------------------------------------------------------------------
// tb_fifo2linebuf
// Directed bench: a queue-based FIFO model feeds the writer; a negedge
// monitor logs every buffer write, line_done and read strobe. A table of
// line scenarios is applied in a loop, followed by hand-written sequences
// for bank stalls and reset mid-line.
// -----------------------------------------------------------------------------
module tb_fifo2linebuf;

  logic       clk125;
  logic       sys_rst;
  logic [1:0] err_flags;
`ifdef LINEBUF_STATS_EN
  logic [15:0] drop_cnt, short_cnt;
`endif

  fifo2linebuf_if #(.ADDR_W(11)) bus ();

  fifo2linebuf #(.H_ACTIVE(1280), .ADDR_W(11)) dut (
    .clk125    (clk125),
    .sys_rst   (sys_rst),
    .bus       (bus.master),
    .err_flags (err_flags)
`ifdef LINEBUF_STATS_EN
    ,
    .drop_cnt  (drop_cnt),
    .short_cnt (short_cnt)
`endif
  );

  initial clk125 = 1'b0;
  always #5 clk125 = ~clk125;

  // FIFO model: data appears the cycle after the strobe; empty flag is
  // refreshed mid-cycle so the writer sees it on its next edge.
  logic [28:0] fq[$];
  always @(posedge clk125)
    if (bus.fifo_rd_en && fq.size() > 0) bus.fifo_dout <= fq.pop_front();
  always @(negedge clk125) bus.fifo_empty = (fq.size() == 0);

  // Monitor (sole writer of the logs; tests index from a saved base).
  int wr_addr[$], wr_data[$], wr_cyc[$];
  int done_num[$], done_bank[$];
  int rd_cnt = 0, consec = 0, cyc = 0;
  logic prev_done = 1'b0;
  always @(negedge clk125) begin
    cyc++;
    if (bus.buf_we) begin
      wr_addr.push_back(int'(bus.buf_addr));
      wr_data.push_back(int'(bus.buf_wdata));
      wr_cyc.push_back(cyc);
    end
    if (bus.line_done) begin
      done_num.push_back(int'(bus.line_num));
      done_bank.push_back(int'(bus.line_bank));
      if (prev_done) consec++;
    end
    prev_done = bus.line_done;
    if (bus.fifo_rd_en) rd_cnt++;
  end

  int n_run = 0, n_fail = 0;
  int k = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wa(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : -1;
  endfunction
  function automatic int wd(input int i);
    return (i < wr_data.size()) ? wr_data[i] : -1;
  endfunction
  function automatic int dn(input int i);
    return (i < done_num.size()) ? done_num[i] : -1;
  endfunction
  function automatic int db(input int i);
    return (i < done_bank.size()) ? done_bank[i] : -1;
  endfunction

  task automatic tick();
    @(negedge clk125);
    #1;
  endtask

  task automatic push(input int y, input int n, input int pbase);
    logic [28:0] w;
    logic [31:0] yv, pv;
    for (int i = 0; i < n; i++) begin
      yv = y;
      pv = pbase + k;
      w = '0;
      w[26:16] = yv[10:0];
      w[15:0]  = pv[15:0];
      fq.push_back(w);
      k++;
    end
  endtask

  task automatic enter_reset();
    tick();
    sys_rst = 1'b1;
    fq.delete();
    k = 0;
    repeat (2) tick();
  endtask

  task automatic drain(input string nm);
    int quiet = 0;
    int t = 0;
    while (quiet < 8 && t < 8000) begin
      tick();
      t++;
      if (fq.size() == 0 && !bus.buf_we) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) begin
      n_run++;
      n_fail++;
      $display("FAIL %s_drain: got timeout, expected idle within 8000 cycles", nm);
    end
  endtask

  task automatic wait_until(input string nm, input int target, input bit on_done);
    int t = 0;
    while (((on_done ? done_num.size() : wr_addr.size()) < target) && t < 6000) begin
      tick();
      t++;
    end
    chk({nm, "_wait"}, (on_done ? done_num.size() : wr_addr.size()) >= target, 1);
  endtask

  typedef struct {
    int y0, n0, y1, n1;
    int exp_wr, exp_done, exp_num, exp_bank;
    logic [1:0] exp_err;
    int chk_idx, exp_addr, exp_span;
  } vec_t;

  vec_t vecs[5];
  int bw, bd, bc, br, w1, r1, bad;

  initial begin
    // full line, short line, overflow drop, full line then next line, partial
    vecs[0] = '{5, 1280, 0, 0,  1280, 1, 5, 0, 2'b00, 1279, 1279, 2558};
    vecs[1] = '{7,  700, 8, 10,  710, 1, 7, 0, 2'b10,  700, 2048,   -1};
    vecs[2] = '{9, 1281, 0, 0,  1280, 1, 9, 0, 2'b01, 1279, 1279,   -1};
    vecs[3] = '{2, 1280, 4, 5,  1285, 1, 2, 0, 2'b00, 1280, 2048,   -1};
    vecs[4] = '{0,    3, 0, 0,     3, 0, 0, 0, 2'b00,    2,    2,   -1};

    sys_rst = 1'b0;
    bus.bank_free = 2'b11;
    #3 sys_rst = 1'b1;
    repeat (2) tick();
    chk("rst_rd_en",     int'(bus.fifo_rd_en), 0);
    chk("rst_buf_we",    int'(bus.buf_we),     0);
    chk("rst_buf_addr",  int'(bus.buf_addr),   0);
    chk("rst_buf_wdata", int'(bus.buf_wdata),  0);
    chk("rst_line_done", int'(bus.line_done),  0);
    chk("rst_line_num",  int'(bus.line_num),   0);
    chk("rst_line_bank", int'(bus.line_bank),  0);
    chk("rst_err",       int'(err_flags),      0);

    for (int i = 0; i < 5; i++) begin
      enter_reset();
      bus.bank_free = 2'b11;
      push(vecs[i].y0, vecs[i].n0, 0);
      push(vecs[i].y1, vecs[i].n1, 0);
      bw = wr_addr.size();
      bd = done_num.size();
      bc = consec;
      sys_rst = 1'b0;
      drain($sformatf("v%0d", i));
      chk($sformatf("v%0d_writes", i), wr_addr.size() - bw, vecs[i].exp_wr);
      chk($sformatf("v%0d_done_cnt", i), done_num.size() - bd, vecs[i].exp_done);
      if (vecs[i].exp_done > 0) begin
        chk($sformatf("v%0d_line_num", i), dn(bd), vecs[i].exp_num);
        chk($sformatf("v%0d_line_bank", i), db(bd), vecs[i].exp_bank);
      end
      chk($sformatf("v%0d_err", i), int'(err_flags), int'(vecs[i].exp_err));
      chk($sformatf("v%0d_first_addr", i), wa(bw), 0);
      chk($sformatf("v%0d_addr", i), wa(bw + vecs[i].chk_idx), vecs[i].exp_addr);
      chk($sformatf("v%0d_data", i), wd(bw + vecs[i].chk_idx), vecs[i].chk_idx);
      if (vecs[i].exp_span >= 0)
        chk($sformatf("v%0d_span", i),
            (bw + vecs[i].chk_idx < wr_cyc.size()) ? wr_cyc[bw + vecs[i].chk_idx] - wr_cyc[bw] : -1,
            vecs[i].exp_span);
      chk($sformatf("v%0d_no_consec_done", i), consec - bc, 0);
    end

    // Bank 1 busy after a full line: no reads until it frees, then {1,0}.
    enter_reset();
    bus.bank_free = 2'b01;
    push(1, 1280, 0);
    push(2, 20, 0);
    bw = wr_addr.size(); bd = done_num.size(); br = rd_cnt;
    sys_rst = 1'b0;
    wait_until("bank_done", bd + 1, 1'b1);
    r1 = rd_cnt;
    repeat (50) tick();
    chk("bank_no_reads", rd_cnt - r1, 0);
    chk("bank_reads", rd_cnt - br, 1280);
    chk("bank_writes_held", wr_addr.size() - bw, 1280);
    chk("bank_done_num", dn(bd), 1);
    bus.bank_free = 2'b11;
    drain("bank");
    chk("bank_writes", wr_addr.size() - bw, 1300);
    chk("bank_resume_addr", wa(bw + 1280), 2048);
    chk("bank_resume_data", wd(bw + 1280), 1280);

    // Bank goes busy mid-line: reads stop, nothing is lost.
    enter_reset();
    bus.bank_free = 2'b11;
    push(6, 300, 0);
    bw = wr_addr.size();
    sys_rst = 1'b0;
    wait_until("stall", bw + 100, 1'b0);
    bus.bank_free = 2'b00;
    repeat (10) tick();
    w1 = wr_addr.size(); r1 = rd_cnt;
    repeat (30) tick();
    chk("stall_no_writes", wr_addr.size() - w1, 0);
    chk("stall_no_reads", rd_cnt - r1, 0);
    bus.bank_free = 2'b11;
    drain("stall");
    chk("stall_writes", wr_addr.size() - bw, 300);
    bad = 0;
    for (int i = 0; i < 300; i++)
      if (wd(bw + i) != i || wa(bw + i) != i) bad++;
    chk("stall_seq_errors", bad, 0);
    chk("stall_err", int'(err_flags), 0);

    // Reset at pixel 400 discards the line; new y=3 line lands at {0,0}.
    enter_reset();
    bus.bank_free = 2'b11;
    push(11, 600, 0);
    bw = wr_addr.size(); bd = done_num.size();
    sys_rst = 1'b0;
    wait_until("rst_mid", bw + 400, 1'b0);
    sys_rst = 1'b1;
    fq.delete();
    #1;
    chk("rst_mid_rd_en", int'(bus.fifo_rd_en), 0);
    chk("rst_mid_buf_we", int'(bus.buf_we), 0);
    chk("rst_mid_addr", int'(bus.buf_addr), 0);
    repeat (2) tick();
    k = 0;
    push(3, 5, 16'h3000);
    sys_rst = 1'b0;
    drain("rst_mid");
    chk("rst_mid_no_done", done_num.size() - bd, 0);
    chk("rst_mid_writes", wr_addr.size() - bw, 405);
    chk("rst_mid_new_addr", wa(bw + 400), 0);
    chk("rst_mid_new_data", wd(bw + 400), 16'h3000);

`ifdef LINEBUF_STATS_EN
    // Three short lines.
    enter_reset();
    bus.bank_free = 2'b11;
    push(20, 10, 0); push(21, 10, 0); push(22, 10, 0); push(23, 10, 0);
    bd = done_num.size();
    sys_rst = 1'b0;
    drain("stats");
    chk("stats_short_cnt", int'(short_cnt), 3);
    chk("stats_drop_cnt", int'(drop_cnt), 0);
    chk("stats_done_cnt", done_num.size() - bd, 3);
    chk("stats_err", int'(err_flags), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo2linebuf.md
FIFO2LINEBUF -- requirements
Module: fifo2linebuf

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, giving pixels per video line.
REQ-002 SHALL have parameter ADDR_W, default 11, giving the in-bank address width (2**ADDR_W >= H_ACTIVE).
REQ-003 SHALL have port clk125, input, 1, the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port fifo_dout, input, 29, the video FIFO word: [27] chunk bit, [26:16] line number y, [15:0] YUV422 pixel.
REQ-006 SHALL have port fifo_empty, input, 1, video FIFO empty flag.
REQ-007 SHALL have port fifo_rd_en, output, 1, FIFO read strobe; standard FIFO, data valid one cycle after the strobe.
REQ-008 SHALL have port bank_free, input, 2, display side marks each line bank writable.
REQ-009 SHALL have port buf_we, output, 1, line-buffer write enable.
REQ-010 SHALL have port buf_addr, output, ADDR_W+1, {bank, pixel index}.
REQ-011 SHALL have port buf_wdata, output, 16, pixel written.
REQ-012 SHALL have port line_done, output, 1, one-cycle pulse when a line is closed.
REQ-013 SHALL have port line_num, output, 11, y of the closed line, valid with line_done.
REQ-014 SHALL have port line_bank, output, 1, bank of the closed line, valid with line_done.
REQ-015 SHALL have port err_flags, output, 2, sticky: [0] overflow pixel dropped, [1] short line.

Function
REQ-016 SHALL implement states IDLE, RD, CHK, STALL.
REQ-017 IDLE SHALL go to RD when !fifo_empty && bank_free[cur_bank]; otherwise it SHALL stay, with fifo_rd_en=0.
REQ-018 RD SHALL assert fifo_rd_en for exactly one cycle and then go to CHK.
REQ-019 CHK SHALL sample fifo_dout and, when y equals cur_y or pix_cnt==0, write the pixel: buf_we=1, buf_addr={cur_bank,pix_cnt}, then pix_cnt+1.
REQ-020 Back-to-back reads SHALL be issued: CHK SHALL return directly to RD when a further read is allowed; sustained throughput SHALL be 1 pixel per 2 cycles.
REQ-021 When pix_cnt reaches H_ACTIVE after a write, the block SHALL pulse line_done with cur_y and cur_bank, toggle cur_bank, clear pix_cnt, and go to IDLE.
REQ-022 When pix_cnt==H_ACTIVE on entry to CHK (line already closed) and y==last closed y, the pixel SHALL be dropped with no write, and err_flags[0] SHALL be set.
REQ-023 When y differs from cur_y with 0<pix_cnt<H_ACTIVE, the block SHALL pulse line_done for the partial line, set err_flags[1], toggle bank, hold the word in a staging register, and go to STALL.
REQ-024 STALL SHALL wait for bank_free[cur_bank], then write the staged pixel at index 0, set cur_y=y, and go to IDLE.
REQ-025 When bank_free[cur_bank] falls mid-line, the in-progress read SHALL complete and further reads SHALL stop; pixels SHALL never be lost to the stall.
REQ-026 pix_cnt SHALL be ADDR_W+1 bits wide and SHALL never wrap; y SHALL be compared as the full 11 bits.
REQ-027 line_done SHALL never be asserted in two consecutive cycles.

Reset
REQ-028 Asserting sys_rst SHALL asynchronously force: state=IDLE, fifo_rd_en=0, buf_we=0, buf_addr=0, buf_wdata=0, line_done=0, line_num=0, line_bank=0, err_flags=0, cur_bank=0, pix_cnt=0, cur_y=0.
REQ-029 Reset mid-line SHALL discard the partial line without a line_done pulse.
REQ-030 Reset release SHALL take effect on the first clk125 edge after deassertion.

Configuration
REQ-031 With LINEBUF_STATS_EN defined, the block SHALL add outputs drop_cnt[15:0] and short_cnt[15:0], saturating at 16'hFFFF and incremented with err_flags[0] and err_flags[1] events respectively.
REQ-032 Without LINEBUF_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 A shared package linebuf_pkg SHALL hold the state encoding and the field positions of the 29-bit word (Y_MSB=26, Y_LSB=16, PIX_MSB=15, CHUNK_BIT=27).
REQ-034 The block SHALL be flat with no sub-module; the line-buffer RAM SHALL be external.

Verification
REQ-035 With 1280 words of y=5 and bank_free=2'b11, the bench SHALL see 1280 writes to addresses 0..1279, then line_done with line_num=5 and line_bank=0.
REQ-036 With 700 words of y=7 followed by words of y=8, the bench SHALL see line_done with line_num=7, err_flags[1]=1, and the first y=8 pixel at addr {1,0}.
REQ-037 With 1281 words of y=9, the bench SHALL see the 1281st word dropped (no write) and err_flags[0]=1.
REQ-038 With bank_free=2'b01 after one full line, fifo_rd_en SHALL stay 0 until bank_free[1]=1, after which writing SHALL resume at {1,0}.
REQ-039 Asserting sys_rst at pixel 400, then feeding a new line of y=3, SHALL give no line_done for the old line and a write of y=3 pixel 0 to addr {0,0}.
REQ-040 With LINEBUF_STATS_EN and 3 short lines, short_cnt SHALL read 3.
